dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the MIPS core's data-memory port: the other end of the core's mem_en / write / address / write-data / read-data interface.
- Replaces the zero-wait block RAM with a wait-state-capable target. It adds a ready handshake, per-byte write enables and out-of-range error reporting.
- Sits in the top level between the mips data port and the on-chip data array. The core stalls its MEM stage until ready is asserted.

Parameters:
- ADDR_WIDTH, 8: word-address bits. The array holds 2^ADDR_WIDTH 32-bit words; valid byte addresses are 0 to 2^(ADDR_WIDTH+2)-1.
- WAIT_CYCLES, 2: wait states inserted between accept and response; range 0 to 15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_en  in  1  request valid from the core; held high until ready.
- mem_we  in  4  byte write enables; bit i writes wdata[8i+7:8i]. All zero means a read.
- addr  in  32  byte address; addr[1:0] ignored.
- wdata  in  32  store data, already lane-aligned by the core.
- rdata  out  32  load data; meaningful only while ready=1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  qualifies ready; the access was out of range.
- io_out  out  32  memory-mapped output register; see Optional Feature.

Behaviour:
- Reset values: rdata=0, ready=0, err=0, io_out=0, state=IDLE, wait counter=0. The data array is NOT reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_en=1, capture addr, mem_we and wdata into request registers, load the counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, else to RESP.
- WAIT: decrement the counter each cycle; when it reaches 1, go to RESP.
- RESP:
  - ready=1 for exactly this cycle.
  - Performs the write, or drives the registered read, using the captured request.
  - Returns to IDLE next cycle.
- Latency: ready is asserted WAIT_CYCLES+1 cycles after the accept edge. The minimum turnaround is 2 cycles per access (RESP, then IDLE accept).
- Requests are ignored outside IDLE. A mem_en already high when RESP returns to IDLE is treated as a new request, so the core must drop mem_en in the ready cycle or be ready to issue again.
- mem_en dropping during WAIT does not abort; the captured access completes and ready still pulses.
- Write: bytes with mem_we[i]=1 update at the RESP edge; other bytes are unchanged. rdata=0 on a write response.
- Read: rdata=array[addr[ADDR_WIDTH+1:2]] presented in RESP; it holds its last value afterwards.
- Read-after-write: the next access observes the written data; there is no forwarding hazard.
- Out of range (addr[31:ADDR_WIDTH+2] != 0 and not the MMIO address): in RESP, err=1 and rdata=0, and no array write occurs.
- Reset during WAIT: the request is discarded, no write occurs and the FSM returns to IDLE. Reset during RESP: the write may or may not land; software must not rely on it.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- Defined:
  - Byte address 0xFFFF_FFF0 maps to io_out.
  - A write updates io_out per byte enable in RESP.
  - A read returns io_out; err=0.
- Undefined: io_out is tied to 0, and that address is treated as out of range (err=1).

Decomposition:
- Package dmem_pkg:
  - state enum (IDLE, WAIT, RESP);
  - MMIO_ADDR constant 32'hFFFF_FFF0;
  - WAIT counter width constant (4).
- Sub-module dmem_ram: single-port synchronous 2^ADDR_WIDTH x 32 array with a 4-bit byte write enable.
- FSM, counter, range check and MMIO register remain in dmem_responder.

Test Plan:
- Reset with rst=1 mid-run -> ready=0, err=0, rdata=0, io_out=0 immediately (asynchronous), FSM in IDLE.
- WAIT_CYCLES=2, write 0xDEADBEEF at 0x10 with mem_we=1111 -> ready on the 3rd edge after accept, err=0. A read of 0x10 then returns rdata=0xDEADBEEF with ready.
- mem_we=0010, wdata=0x0000AB00 to 0x10, then read 0x10 -> 0xDEADABEF.
- ADDR_WIDTH=8, write to 0x400 -> ready with err=1, rdata=0. A read of 0x000 afterwards shows the data at word 0 unchanged.
- rst pulsed during WAIT of a write 0x11111111 to 0x20 -> a later read of 0x20 returns the prior value; no ready pulse for the aborted request.
- DMEM_MMIO_EN defined, write 0x5A to 0xFFFFFFF0 -> io_out=0x0000005A; a read returns 0x5A, err=0. With the macro undefined, the same write -> err=1 and io_out stays 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;
  localparam int unsigned CNT_W     = 4;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous 2^ADDR_WIDTH x 32 data array with byte write enables.
module dmem_ram #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           q
);

  logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (we == '0) q <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory target for the MIPS core's data port.
// Build option: define DMEM_MMIO_EN to map io_out at byte address 0xFFFF_FFF0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [31:0] io_out
);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       req_addr, req_wdata;
  logic [3:0]        req_we;

  logic [31:0]       cur_addr, cur_wdata;
  logic [3:0]        cur_we;
  logic              is_mmio, oor, is_write, enter_resp;

  logic [31:0]       rdata_q, ram_q;
  logic              use_ram;
  logic              ram_en;
  logic [3:0]        ram_we;

  // With WAIT_CYCLES=0 the array read happens on the accept edge itself,
  // so decode works on the live inputs in IDLE and on the captured request otherwise.
  assign cur_addr  = (state == IDLE) ? addr   : req_addr;
  assign cur_we    = (state == IDLE) ? mem_we : req_we;
  assign cur_wdata = (state == IDLE) ? wdata  : req_wdata;
  assign is_write  = (cur_we != '0);
  assign oor       = ((cur_addr >> (ADDR_WIDTH + 2)) != '0) && !is_mmio;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (mem_en) state_nx = (WAIT_CYCLES != 0) ? WAIT : RESP;
      WAIT:    if (cnt <= CNT_W'(1)) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign enter_resp = (state_nx == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_addr  <= '0;
      req_we    <= '0;
      req_wdata <= '0;
      rdata_q   <= '0;
      use_ram   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (mem_en) begin
            cnt       <= CNT_W'(WAIT_CYCLES);
            req_addr  <= addr;
            req_we    <= mem_we;
            req_wdata <= wdata;
          end
        end
        WAIT:    cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
      if (enter_resp) begin
        use_ram <= !oor && !is_mmio && !is_write;
        rdata_q <= (is_mmio && !is_write) ? io_out : '0;
      end
    end
  end

  assign ram_we = (state == RESP && !oor && !is_mmio) ? req_we : '0;
  assign ram_en = (enter_resp && !oor && !is_mmio && !is_write) || (ram_we != '0);

  dmem_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .idx   (cur_addr[ADDR_WIDTH+1:2]),
    .wdata (cur_wdata),
    .q     (ram_q)
  );

  assign ready = (state == RESP);
  assign err   = ready && oor;
  assign rdata = use_ram ? ram_q : rdata_q;

`ifdef DMEM_MMIO_EN
  logic [31:0] io_q;

  assign is_mmio = (cur_addr[31:2] == MMIO_ADDR[31:2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_q <= '0;
    end else if (state == RESP && is_mmio) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (req_we[i]) io_q[8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  assign io_out = io_q;
`else
  assign is_mmio = 1'b0;
  assign io_out  = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (ADDR_WIDTH=8, WAIT_CYCLES=2).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en = 1'b0;
  logic [3:0]  mem_we = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic [31:0] io_out;

  int checks = 0;
  int errors = 0;

  dmem_responder #(
    .ADDR_WIDTH  (8),
    .WAIT_CYCLES (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .mem_en (mem_en),
    .mem_we (mem_we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .ready  (ready),
    .err    (err),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  // Issues one request; lat = negedges from accept until ready (-1 on timeout).
  task automatic access(input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd,
                        input bit hold, output logic [31:0] rd, output logic e, output int lat);
    lat = -1;
    rd  = '0;
    e   = 1'b0;
    @(negedge clk);
    mem_en = 1'b1; mem_we = we; addr = a; wdata = wd;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (!hold) mem_en = 1'b0;
      if (ready) begin
        rd = rdata; e = err; lat = n; mem_en = 1'b0;
        break;
      end
    end
    mem_en = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 || io_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: ready=%b err=%b rdata=%h io_out=%h expected 0 0 0 0",
               ready, err, rdata, io_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    logic [31:0] rd; logic e; int lat;
    access(4'b1111, 32'h10, 32'hDEADBEEF, 1'b1, rd, e, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    checks++;
    if (e !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL wr_resp: err=%b rdata=%h expected 0 00000000", e, rd);
    end
    access(4'b0000, 32'h10, 32'h0, 1'b1, rd, e, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
      errors++; $display("FAIL rd_data: rdata=%h err=%b expected deadbeef 0", rd, e);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_pulse_hold: ready=%b rdata=%h expected 0 deadbeef", ready, rdata);
    end
  endtask

  task automatic test_byte_write;
    logic [31:0] rd; logic e; int lat;
    access(4'b0010, 32'h10, 32'h0000AB00, 1'b1, rd, e, lat);
    access(4'b0000, 32'h10, 32'h0, 1'b1, rd, e, lat);
    checks++;
    if (rd !== 32'hDEADABEF || lat !== 3) begin
      errors++; $display("FAIL byte_write: rdata=%h lat=%0d expected deadabef 3", rd, lat);
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd; logic e; int lat;
    access(4'b1111, 32'h0, 32'h01234567, 1'b1, rd, e, lat);
    access(4'b1111, 32'h400, 32'hFFFFFFFF, 1'b1, rd, e, lat);
    checks++;
    if (e !== 1'b1 || rd !== 32'h0 || lat !== 3) begin
      errors++; $display("FAIL oor_write: err=%b rdata=%h lat=%0d expected 1 00000000 3", e, rd, lat);
    end
    access(4'b0000, 32'h0, 32'h0, 1'b1, rd, e, lat);
    checks++;
    if (rd !== 32'h01234567 || e !== 1'b0) begin
      errors++; $display("FAIL oor_no_alias: rdata=%h err=%b expected 01234567 0", rd, e);
    end
    access(4'b0000, 32'h400, 32'h0, 1'b1, rd, e, lat);
    checks++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL oor_read: err=%b rdata=%h expected 1 00000000", e, rd);
    end
    access(4'b1111, 32'h3FC, 32'hCAFEF00D, 1'b1, rd, e, lat);
    access(4'b0000, 32'h3FF, 32'h0, 1'b1, rd, e, lat);
    checks++;
    if (rd !== 32'hCAFEF00D || e !== 1'b0) begin
      errors++; $display("FAIL top_word: rdata=%h err=%b expected cafef00d 0", rd, e);
    end
  endtask

  task automatic test_drop_during_wait;
    logic [31:0] rd; logic e; int lat;
    access(4'b0000, 32'h10, 32'h0, 1'b0, rd, e, lat);
    checks++;
    if (lat !== 3 || rd !== 32'hDEADABEF) begin
      errors++; $display("FAIL drop_en: lat=%0d rdata=%h expected 3 deadabef", lat, rd);
    end
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] rd; logic e; int lat;
    bit saw_ready;
    access(4'b1111, 32'h20, 32'h22222222, 1'b1, rd, e, lat);
    @(negedge clk);
    mem_en = 1'b1; mem_we = 4'b1111; addr = 32'h20; wdata = 32'h11111111;
    @(negedge clk);
    rst = 1'b1; mem_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    saw_ready = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready) saw_ready = 1'b1;
    end
    checks++;
    if (saw_ready !== 1'b0) begin
      errors++; $display("FAIL abort_ready: saw ready=%b expected 0", saw_ready);
    end
    access(4'b0000, 32'h20, 32'h0, 1'b1, rd, e, lat);
    checks++;
    if (rd !== 32'h22222222 || lat !== 3) begin
      errors++; $display("FAIL abort_nowrite: rdata=%h lat=%0d expected 22222222 3", rd, lat);
    end
  endtask

  task automatic test_mmio;
    logic [31:0] rd; logic e; int lat;
    access(4'b0001, 32'hFFFFFFF0, 32'h0000005A, 1'b1, rd, e, lat);
`ifdef DMEM_MMIO_EN
    checks++;
    if (e !== 1'b0 || io_out !== 32'h5A) begin
      errors++; $display("FAIL mmio_write: err=%b io_out=%h expected 0 0000005a", e, io_out);
    end
    access(4'b0000, 32'hFFFFFFF0, 32'h0, 1'b1, rd, e, lat);
    checks++;
    if (rd !== 32'h5A || e !== 1'b0) begin
      errors++; $display("FAIL mmio_read: rdata=%h err=%b expected 0000005a 0", rd, e);
    end
`else
    checks++;
    if (e !== 1'b1 || io_out !== 32'h0) begin
      errors++; $display("FAIL mmio_off_write: err=%b io_out=%h expected 1 00000000", e, io_out);
    end
    access(4'b0000, 32'hFFFFFFF0, 32'h0, 1'b1, rd, e, lat);
    checks++;
    if (rd !== 32'h0 || e !== 1'b1) begin
      errors++; $display("FAIL mmio_off_read: rdata=%h err=%b expected 00000000 1", rd, e);
    end
`endif
  endtask

  task automatic test_reset_midrun;
    logic [31:0] rd; logic e; int lat;
    access(4'b0000, 32'h10, 32'h0, 1'b1, rd, e, lat);
    checks++;
    if (ready !== 1'b1 || rdata !== 32'hDEADABEF) begin
      errors++; $display("FAIL pre_reset: ready=%b rdata=%h expected 1 deadabef", ready, rdata);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 || io_out !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: ready=%b err=%b rdata=%h io_out=%h expected 0 0 0 0",
               ready, err, rdata, io_out);
    end
    @(negedge clk);
    rst = 1'b0;
    access(4'b0000, 32'h10, 32'h0, 1'b1, rd, e, lat);
    checks++;
    if (lat !== 3 || rd !== 32'hDEADABEF) begin
      errors++; $display("FAIL post_reset: lat=%0d rdata=%h expected 3 deadabef", lat, rd);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_write();
    test_out_of_range();
    test_drop_during_wait();
    test_reset_in_wait();
    test_mmio();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
